uart_cmd_link: RTL and testbench

UART_CMD_LINK -- requirements
Module: uart_cmd_link

---
 rtl/uart_cmd_pkg.sv | 20 ++
 rtl/uart_rx_byte.sv | 111 +++++++++++
 rtl/uart_cmd_link.sv | 161 ++++++++++++++++
 tb/tb_uart_cmd_link.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and widths for the UART command link
package uart_cmd_pkg;

  localparam int CMD_W = 24;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - UART byte receiver: 2-flop sync, mid-bit sampling FSM, shift register
module uart_rx_byte
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       rx_start
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  rx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              sync1_q, sync2_q, prev_q;
  logic              fall, half_tick, full_tick;

  assign fall      = prev_q & ~sync2_q;
  assign half_tick = (baud_q == HALF_LAST);
  assign full_tick = (baud_q == FULL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      // A start bit that is high again at mid-bit was a glitch
      RX_START: if (half_tick) state_d = sync2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_tick && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (full_tick) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_START: if (half_tick) baud_d = '0;
      RX_DATA: begin
        if (full_tick) begin
          baud_d  = '0;
          bit_d   = bit_q + 3'd1;
          shift_d = {sync2_q, shift_q[7:1]};
        end
      end
      RX_STOP: begin
        if (full_tick) begin
          baud_d = '0;
          if (sync2_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        baud_d = '0;
        bit_d  = '0;
      end
    endcase
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;
  assign rx_start = (state_q == RX_IDLE) && fall;

endmodule

// File: rtl/uart_cmd_link.sv
// rtl/uart_cmd_link.sv - 3-byte host command assembler with inter-byte timeout and response transmitter
module uart_cmd_link
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX,
  output logic             TX,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic [7:0]       resp_data,
  input  logic             send_resp,
  output logic             resp_sent
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int TO_W = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr, rx_start;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_i     (RX),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rx_start (rx_start)
  );

  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             rdy_q, rdy_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]  to_q, to_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q      <= '0;
      rdy_q      <= 1'b0;
      byte_cnt_q <= '0;
      to_q       <= '0;
    end else begin
      cmd_q      <= cmd_d;
      rdy_q      <= rdy_d;
      byte_cnt_q <= byte_cnt_d;
      to_q       <= to_d;
    end
  end

  always_comb begin
    cmd_d      = cmd_q;
    rdy_d      = rdy_q;
    byte_cnt_d = byte_cnt_q;
    to_d       = to_q + 1'b1;
    if (clr_cmd_rdy) rdy_d = 1'b0;
    // Gap timer restarts on every start edge and only runs mid-command
    if (byte_cnt_q == 2'd0 || rx_start) begin
      to_d = '0;
    end else if (to_q == TO_LAST) begin
      to_d       = '0;
      byte_cnt_d = 2'd0;
    end
    if (rx_ferr) begin
      byte_cnt_d = 2'd0;
    end else if (rx_valid && !rdy_q) begin
      case (byte_cnt_q)
        2'd0: begin
          cmd_d[CMD_W-1 -: 8] = rx_data;
          byte_cnt_d          = 2'd1;
        end
        2'd1: begin
          cmd_d[15:8] = rx_data;
          byte_cnt_d  = 2'd2;
        end
        default: begin
          cmd_d[7:0] = rx_data;
          byte_cnt_d = 2'd0;
          rdy_d      = 1'b1;
        end
      endcase
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = rdy_q;

  tx_state_e         tx_state_q, tx_state_d;
  logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              tx_full;

  assign tx_full = (tx_baud_q == FULL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:  if (send_resp) tx_state_d = TX_START;
      TX_START: if (tx_full) tx_state_d = TX_DATA;
      TX_DATA:  if (tx_full && tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      TX_STOP:  if (tx_full) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_baud_d  = tx_baud_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_baud_d = '0;
        tx_bit_d  = '0;
        if (send_resp) tx_shift_d = resp_data;
      end
      TX_DATA: begin
        if (tx_full) begin
          tx_baud_d  = '0;
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end
      end
      default: if (tx_full) tx_baud_d = '0;
    endcase
  end

  always_comb begin
    TX        = 1'b1;
    resp_sent = 1'b0;
    case (tx_state_q)
      TX_START: TX = 1'b0;
      TX_DATA:  TX = tx_shift_q[0];
      TX_STOP:  resp_sent = tx_full;
      default:  TX = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_link.sv
// tb/tb_uart_cmd_link.sv - directed bench for uart_cmd_link with CLKS_PER_BIT=16, TIMEOUT_BITS=32
module tb_uart_cmd_link;

  localparam int CPB = 16;
  localparam int TOB = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic        TX, cmd_rdy, resp_sent;
  logic [23:0] cmd;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rise_cyc = -1;
  logic rdy_last = 1'b0;
  logic tx_s [0:199];
  logic rs_s [0:199];

  uart_cmd_link #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp_data  (resp_data),
    .send_resp  (send_resp),
    .resp_sent  (resp_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_rdy && !rdy_last) rise_cyc = cyc;
    rdy_last = cmd_rdy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    RX = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge clk);
    end
    RX = stop_bit;
    repeat (CPB) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic tx_frame(input logic [7:0] d, input string tag);
    int cnt;
    int at;
    cnt = 0;
    at  = -1;
    @(negedge clk);
    check({tag, "_idle_before"}, 32'(TX), 32'd1);
    resp_data = d;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    resp_data = 8'h00;
    for (int n = 0; n < 200; n++) begin
      tx_s[n] = TX;
      rs_s[n] = resp_sent;
      send_resp = (n == 50);
      @(negedge clk);
    end
    send_resp = 1'b0;
    check({tag, "_start_first"}, 32'(tx_s[0]), 32'd0);
    check({tag, "_start_last"}, 32'(tx_s[15]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_bit%0d_first", tag, i), 32'(tx_s[16 + 16 * i]), 32'(d[i]));
      check($sformatf("%s_bit%0d_last", tag, i), 32'(tx_s[31 + 16 * i]), 32'(d[i]));
    end
    check({tag, "_stop_first"}, 32'(tx_s[144]), 32'd1);
    check({tag, "_stop_last"}, 32'(tx_s[159]), 32'd1);
    check({tag, "_idle_after"}, 32'(tx_s[199]), 32'd1);
    for (int n = 0; n < 200; n++) begin
      if (rs_s[n]) begin
        cnt++;
        at = n;
      end
    end
    check({tag, "_sent_count"}, 32'(cnt), 32'd1);
    check({tag, "_sent_at"}, 32'(at), 32'd159);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_sent", 32'(resp_sent), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_byte(8'h02, 1'b1);
    send_byte(8'hA5, 1'b1);
    check("cmd1_rdy_early", 32'(cmd_rdy), 32'd0);
    rise_cyc = -1;
    send_byte(8'h3C, 1'b1);
    check("cmd1_value", 32'(cmd), 32'h02A53C);
    check("cmd1_rdy", 32'(cmd_rdy), 32'd1);
    check("cmd1_latency", 32'(rise_cyc - start_cyc), 32'd156);

    send_byte(8'hFF, 1'b1);
    check("drop_cmd_hold", 32'(cmd), 32'h02A53C);
    check("drop_rdy_hold", 32'(cmd_rdy), 32'd1);
    pulse_clr();
    check("clr_rdy", 32'(cmd_rdy), 32'd0);
    check("clr_cmd_hold", 32'(cmd), 32'h02A53C);
    pulse_clr();
    check("clr_idle_rdy", 32'(cmd_rdy), 32'd0);

    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    check("cmd2_value", 32'(cmd), 32'h112233);
    check("cmd2_rdy", 32'(cmd_rdy), 32'd1);
    pulse_clr();

    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (600) @(negedge clk);
    check("timeout_rdy", 32'(cmd_rdy), 32'd0);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    check("timeout_cmd", 32'(cmd), 32'hAABBCC);
    check("timeout_cmd_rdy", 32'(cmd_rdy), 32'd1);
    pulse_clr();

    send_byte(8'h10, 1'b1);
    send_byte(8'h55, 1'b0);
    check("ferr_cmd", 32'(cmd), 32'h10BBCC);
    check("ferr_rdy", 32'(cmd_rdy), 32'd0);
    send_byte(8'hD1, 1'b1);
    send_byte(8'hE2, 1'b1);
    send_byte(8'hF3, 1'b1);
    check("ferr_next_cmd", 32'(cmd), 32'hD1E2F3);
    check("ferr_next_rdy", 32'(cmd_rdy), 32'd1);
    pulse_clr();

    tx_frame(8'hC3, "tx1");

    send_byte(8'h0A, 1'b1);
    send_byte(8'h0B, 1'b1);
    send_byte(8'h0C, 1'b1);
    check("pre_rst_rdy", 32'(cmd_rdy), 32'd1);
    @(negedge clk);
    resp_data = 8'h5A;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    RX = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_tx", 32'(TX), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tx", 32'(TX), 32'd1);
    check("mid_rst_rdy", 32'(cmd_rdy), 32'd0);
    check("mid_rst_cmd", 32'(cmd), 32'h0);
    check("mid_rst_sent", 32'(resp_sent), 32'd0);
    RX = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_rdy", 32'(cmd_rdy), 32'd0);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'h42, 1'b1);
    check("post_rst_cmd", 32'(cmd), 32'hDEAD42);
    check("post_rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    tx_frame(8'h96, "tx2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
